// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, default widths and saturation limits.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PADDSB = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned LANE_DEF  = 4;

  localparam logic [15:0] SAT_MAX16 = 16'h7fff;
  localparam logic [15:0] SAT_MIN16 = 16'h8000;
  localparam logic [3:0]  SAT_MAX4  = 4'h7;
  localparam logic [3:0]  SAT_MIN4  = 4'h8;

endpackage

// File: rtl/addsub_pipe_cla4.sv
// 4-bit carry-lookahead slice with group P/G and MSB overflow; lane_mode_i cuts the carry-in
// so the slice behaves as an isolated PADDSB lane.
module addsub_pipe_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  input  logic       lane_mode_i,
  output logic [3:0] s_o,
  output logic       p_o,
  output logic       g_o,
  output logic       ovf_o
);

  logic [3:0] p, g;
  logic       c0, c1, c2, c3, c4;

  assign p  = a_i ^ b_i;
  assign g  = a_i & b_i;
  assign c0 = c_i & ~lane_mode_i;

  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (&p[2:0] & c0);

  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (&p[3:1] & g[0]);
  assign p_o = &p;
  assign c4  = g_o | (p_o & c0);

  assign s_o   = p ^ {c3, c2, c1, c0};
  assign ovf_o = c3 ^ c4;

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage ADD/SUB/PADDSB pipeline: low half in stage 1, high half plus flags in stage 2.
// Saturation is built only when ADDSUB_PIPE_SAT_EN is defined; otherwise results wrap.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANE  = LANE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int unsigned Half    = WIDTH / 2;
  localparam int unsigned NibHalf = Half / LANE;
  localparam int unsigned Nib     = WIDTH / LANE;

  op_e              op_in;
  logic             in_sub, in_lane, in_xfer, s2_advance;
  logic [WIDTH-1:0] b_cond;
  logic [Half-1:0]  lo_sum;
  logic [NibHalf:0] lo_c;
  logic [NibHalf-1:0] lo_p, lo_g, lo_ovf;

  logic               s1_valid_q, s1_carry_q;
  logic [Half-1:0]    s1_sum_lo_q, s1_a_hi_q, s1_b_hi_q;
  op_e                s1_op_q;
  logic [NibHalf-1:0] s1_lane_ovf_q;

  logic               s1_lane, raw_v;
  logic [Half-1:0]    hi_sum;
  logic [NibHalf-1:0] hi_c, hi_p, hi_g, hi_ovf;
  logic [WIDTH-1:0]   raw, sat_res;
  logic [Nib-1:0]     lane_ovf_all;

  logic             out_valid_q, z_q, v_q, n_q;
  logic [WIDTH-1:0] result_q;

  assign s2_advance = ~out_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_advance;
  assign in_xfer    = in_valid & in_ready;

  assign op_in   = op_e'(op);
  assign in_sub  = (op_in == OP_SUB);
  assign in_lane = (op_in == OP_PADDSB);
  assign b_cond  = in_sub ? ~b : b;
  assign lo_c[0] = in_sub;

  for (genvar k = 0; k < NibHalf; k++) begin : g_lo
    addsub_pipe_cla4 u_cla (
      .a_i        (a[k*LANE +: LANE]),
      .b_i        (b_cond[k*LANE +: LANE]),
      .c_i        (lo_c[k]),
      .lane_mode_i(in_lane),
      .s_o        (lo_sum[k*LANE +: LANE]),
      .p_o        (lo_p[k]),
      .g_o        (lo_g[k]),
      .ovf_o      (lo_ovf[k])
    );
    assign lo_c[k+1] = lo_g[k] | (lo_p[k] & lo_c[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_carry_q    <= 1'b0;
      s1_sum_lo_q   <= '0;
      s1_a_hi_q     <= '0;
      s1_b_hi_q     <= '0;
      s1_op_q       <= OP_ADD;
      s1_lane_ovf_q <= '0;
    end else if (in_xfer) begin
      s1_valid_q    <= 1'b1;
      s1_carry_q    <= lo_c[NibHalf] & ~in_lane;
      s1_sum_lo_q   <= lo_sum;
      s1_a_hi_q     <= a[WIDTH-1:Half];
      s1_b_hi_q     <= b_cond[WIDTH-1:Half];
      s1_op_q       <= op_in;
      s1_lane_ovf_q <= lo_ovf;
    end else if (s2_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  assign s1_lane = (s1_op_q == OP_PADDSB);
  assign hi_c[0] = s1_carry_q;

  for (genvar k = 0; k < NibHalf; k++) begin : g_hi
    addsub_pipe_cla4 u_cla (
      .a_i        (s1_a_hi_q[k*LANE +: LANE]),
      .b_i        (s1_b_hi_q[k*LANE +: LANE]),
      .c_i        (hi_c[k]),
      .lane_mode_i(s1_lane),
      .s_o        (hi_sum[k*LANE +: LANE]),
      .p_o        (hi_p[k]),
      .g_o        (hi_g[k]),
      .ovf_o      (hi_ovf[k])
    );
    if (k < NibHalf - 1) begin : g_chain
      assign hi_c[k+1] = hi_g[k] | (hi_p[k] & hi_c[k]);
    end
  end

  assign raw          = {hi_sum, s1_sum_lo_q};
  assign lane_ovf_all = {hi_ovf, s1_lane_ovf_q};
  assign raw_v        = s1_lane ? |lane_ovf_all : hi_ovf[NibHalf-1];

`ifdef ADDSUB_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow the wrapped sign is the inverse of the operand sign, so it picks the clamp.
  always_comb begin
    sat_res = raw;
    if (s1_lane) begin
      for (int l = 0; l < Nib; l++) begin
        if (lane_ovf_all[l]) begin
          sat_res[l*LANE +: LANE] = raw[l*LANE + LANE - 1] ? SAT_MAX4 : SAT_MIN4;
        end
      end
    end else if (raw_v) begin
      sat_res = raw[WIDTH-1] ? SatMax : SatMin;
    end
  end
`else
  assign sat_res = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
    end else if (s2_advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= sat_res;
        z_q      <= (sat_res == '0);
        v_q      <= raw_v;
        n_q      <= sat_res[WIDTH-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: reset, latency, stalled stream with scoreboard, async reset.
module tb_addsub_pipe;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        flag_z, flag_v, flag_n;

  always #5 clk = ~clk;

  addsub_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n)
  );

  logic [1:0]  v_op [NV] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2,
                             2'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
  logic [15:0] v_a  [NV] = '{16'h1234, 16'h8000, 16'h7171, 16'hffff, 16'h7fff, 16'h0005,
                             16'h8888, 16'h1234, 16'h0001, 16'h1234, 16'h00ff, 16'h0f0f,
                             16'h7fff, 16'h00f0};
  logic [15:0] v_b  [NV] = '{16'h0f0f, 16'h0001, 16'h1111, 16'h0001, 16'h0001, 16'h0007,
                             16'h8888, 16'h1234, 16'h0002, 16'h4321, 16'h0001, 16'h0101,
                             16'hffff, 16'h0010};
  logic        v_ov [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_PIPE_SAT_EN
  logic [15:0] v_res[NV] = '{16'h2143, 16'h8000, 16'h7272, 16'h0000, 16'h7fff, 16'hfffe,
                             16'h8888, 16'h0000, 16'h0003, 16'h5555, 16'h0100, 16'h0000,
                             16'h7fff, 16'h0100};
`else
  logic [15:0] v_res[NV] = '{16'h2143, 16'h7fff, 16'h8282, 16'h0000, 16'h8000, 16'hfffe,
                             16'h0000, 16'h0000, 16'h0003, 16'h5555, 16'h0100, 16'h0000,
                             16'h8000, 16'h0100};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input int k);
    check_eq({tag, "_res"}, 32'(result), 32'(v_res[k]));
    check_eq({tag, "_v"}, 32'(flag_v), 32'(v_ov[k]));
    check_eq({tag, "_z"}, 32'(flag_z), 32'(v_res[k] == 16'h0000));
    check_eq({tag, "_n"}, 32'(flag_n), 32'(v_res[k][15]));
  endtask

  task automatic drive(input int k);
    in_valid = 1'b1;
    op       = v_op[k];
    a        = v_a[k];
    b        = v_b[k];
  endtask

  // Scoreboard: queue of accepted vector indices, popped on each output transfer.
  bit          mon_en = 1'b0;
  int          q[$];
  int          cur = 0;
  int          popped = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_res = '0;

  always @(negedge clk) begin
    int k;
    if (mon_en) begin
      if (prev_stall && out_valid) check_eq("hold_stable", 32'(result), 32'(prev_res));
      check_eq("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      if (in_valid && in_ready) q.push_back(cur);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          k = q.pop_front();
          check_vec($sformatf("stream%0d", k), k);
          popped++;
        end
      end
    end
  end

  initial begin
    int idx;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_z", 32'(flag_z), 32'd0);
    check_eq("rst_v", 32'(flag_v), 32'd0);
    check_eq("rst_n_flag", 32'(flag_n), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-beat latency
    out_ready = 1'b1;
    drive(0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("lat_t1_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_t2_valid", 32'(out_valid), 32'd1);
    check_vec("lat", 0);
    @(posedge clk);
    #1;
    check_eq("lat_drain", 32'(out_valid), 32'd0);

    // Back-to-back stream with out_ready pattern 1,0,0,1
    q.delete();
    popped = 0;
    idx    = 0;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 300 && popped < NV; cyc++) begin
      @(posedge clk);
      #1;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (idx < NV) begin
        drive(idx);
        cur = idx;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk);
    #1;
    mon_en   = 1'b0;
    in_valid = 1'b0;
    check_eq("stream_count", 32'(popped), 32'(NV));
    check_eq("stream_left", 32'(q.size()), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(4);
    @(posedge clk);
    #1;
    drive(5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(out_valid), 32'd0);
    check_eq("rst_async_res", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(9);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int t = 0; t < 10 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    check_eq("post_rst_seen", 32'(out_valid), 32'd1);
    check_vec("post_rst", 9);
    @(posedge clk);
    #1;
    check_eq("post_rst_single", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
